// File: rtl/mem_wb.sv
// MEM/WB pipeline register: formats load data, qualifies the register-file write,
// flags misaligned loads (sticky) and counts retired instructions.
module mem_wb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             InValid,
    input  logic             RegWrite,
    input  logic             MemToReg,
    input  logic [2:0]       LoadType,
    input  logic [1:0]       ByteAddr,
    input  logic [4:0]       WriteReg,
    input  logic [31:0]      AluResult,
    input  logic [31:0]      MemData,
    output logic             WbValid,
    output logic             WbRegWrite,
    output logic [4:0]       WbWriteReg,
    output logic [31:0]      WbData,
    output logic             AlignErr,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    function automatic logic [31:0] formatLoad(input logic [2:0]  loadType,
                                               input logic [1:0]  byteAddr,
                                               input logic [31:0] word);
        logic signed [7:0]  selByte;
        logic signed [15:0] selHalf;
        logic signed [31:0] byteExt;
        logic signed [31:0] halfExt;
        selByte = word[{byteAddr, 3'b000} +: 8];
        selHalf = byteAddr[1] ? word[31:16] : word[15:0];
        byteExt = selByte;
        halfExt = selHalf;
        case (loadType)
            LD_LB:   formatLoad = byteExt;
            LD_LBU:  formatLoad = {24'd0, selByte};
            LD_LH:   formatLoad = halfExt;
            LD_LHU:  formatLoad = {16'd0, selHalf};
            default: formatLoad = word;
        endcase
    endfunction

    // Unknown load codes behave as lw, so they need word alignment too.
    function automatic logic isMisaligned(input logic       valid,
                                          input logic       memToReg,
                                          input logic [2:0] loadType,
                                          input logic [1:0] byteAddr);
        logic isByte;
        logic isHalf;
        isByte = (loadType == LD_LB) || (loadType == LD_LBU);
        isHalf = (loadType == LD_LH) || (loadType == LD_LHU);
        if (!valid || !memToReg || isByte)
            isMisaligned = 1'b0;
        else if (isHalf)
            isMisaligned = byteAddr[0];
        else
            isMisaligned = (byteAddr != 2'b00);
    endfunction

    logic        misaligned_p0;
    logic        regWrite_p0;
    logic [31:0] wbData_p0;

    always_comb begin
        misaligned_p0 = isMisaligned(InValid, MemToReg, LoadType, ByteAddr);
        regWrite_p0   = InValid & RegWrite & (WriteReg != 5'd0) & ~misaligned_p0;
        wbData_p0     = MemToReg ? formatLoad(LoadType, ByteAddr, MemData) : AluResult;
    end

    // ---- MEM -> WB boundary ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WbValid    <= 1'b0;
            WbRegWrite <= 1'b0;
            WbWriteReg <= 5'd0;
            WbData     <= 32'd0;
            AlignErr   <= 1'b0;
            RetireCnt  <= '0;
        end else if (Flush) begin
            WbValid    <= 1'b0;
            WbRegWrite <= 1'b0;
            WbWriteReg <= 5'd0;
            WbData     <= 32'd0;
        end else if (!Stall) begin
            WbValid    <= InValid;
            WbRegWrite <= regWrite_p0;
            WbWriteReg <= WriteReg;
            WbData     <= wbData_p0;
            if (misaligned_p0)
                AlignErr <= 1'b1;
            if (InValid)
                RetireCnt <= RetireCnt + CNT_W'(1);
        end
    end

endmodule
